// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - MIO responder address map, FSM states and address decode (timer window gated by MIO_TIMER_EN)
package mio_pkg;

    localparam logic [31:0] MIO_RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] MIO_IO_BASE    = 32'hF000_0000;
    localparam logic [31:0] MIO_LED_ADDR   = MIO_IO_BASE + 32'h0;
    localparam logic [31:0] MIO_SW_ADDR    = MIO_IO_BASE + 32'h4;
    localparam logic [31:0] MIO_TIMER_ADDR = MIO_IO_BASE + 32'h8;

`ifdef MIO_TIMER_EN
    localparam bit MIO_HAS_TIMER = 1'b1;
`else
    localparam bit MIO_HAS_TIMER = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } mio_state_e;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_TIMER,
        REG_NONE
    } mio_region_e;

    // Word-granular decode; byte offset bits never take part in a match.
    function automatic mio_region_e mio_decode(input logic [31:0] addr, input int unsigned ram_words);
        logic [31:0] ram_off;
        ram_off = addr - MIO_RAM_BASE;
        if ((ram_off >> 2) < ram_words)
            mio_decode = REG_RAM;
        else if (addr[31:2] == MIO_LED_ADDR[31:2])
            mio_decode = REG_LED;
        else if (addr[31:2] == MIO_SW_ADDR[31:2])
            mio_decode = REG_SW;
        else if (MIO_HAS_TIMER && (addr[31:2] == MIO_TIMER_ADDR[31:2]))
            mio_decode = REG_TIMER;
        else
            mio_decode = REG_NONE;
    endfunction

endpackage

// File: rtl/mio_ram.sv
// rtl/mio_ram.sv - single-port synchronous word RAM with registered read
module mio_ram #(
    parameter int RAM_WORDS = 1024,
    parameter int ADDR_W    = $clog2(RAM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [RAM_WORDS];

    // Write wins over read; read data stays stable until the next read enable.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        else if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - MIO bus responder: wait-state FSM, RAM/GPIO decode, optional cycle timer (MIO_TIMER_EN)
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int RAM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int GPIO_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       Addr_out,
    input  logic [31:0]       Data_out,
    output logic              MIO_ready,
    output logic [31:0]       Data_in,
    input  logic [GPIO_W-1:0] sw_in,
    output logic [GPIO_W-1:0] led_out,
    output logic              bus_err
);

    localparam int         ADDR_W    = $clog2(RAM_WORDS);
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    mio_state_e  state_q, state_d;
    logic [3:0]  wait_cnt_q;
    logic [31:0] addr_q, wdata_q;
    logic        mem_w_q;
    mio_region_e region_q;

    logic [31:0] cur_addr;
    mio_region_e cur_region;
    logic        enter_ack;
    logic        commit;

    logic [GPIO_W-1:0] sw_q;
    logic [GPIO_W-1:0] led_q;
    logic              bus_err_q;
    logic [31:0]       io_rdata_d, io_rdata_q;
    logic [31:0]       ram_rdata;

`ifdef MIO_TIMER_EN
    logic [31:0] timer_q;

    // Free-running cycle timer, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset)
            timer_q <= '0;
        else
            timer_q <= timer_q + 32'd1;
    end
`endif

    // In IDLE the request has not been latched yet, so zero-wait reads look at the live bus.
    assign cur_addr   = (state_q == IDLE) ? Addr_out : addr_q;
    assign cur_region = mio_decode(cur_addr, RAM_WORDS);
    assign enter_ack  = (state_d == ACK) && (state_q != ACK);
    assign commit     = (state_q == ACK) && mem_w_q && !reset;

    // Next-state logic for the request handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (CPU_MIO) state_d = (WAIT_CYCLES == 0) ? ACK : WAIT;
            WAIT: if (wait_cnt_q == WAIT_LAST) state_d = ACK;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, wait counter and architected registers; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            led_q      <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == WAIT && state_d != ACK)
                wait_cnt_q <= wait_cnt_q + 4'd1;
            else
                wait_cnt_q <= '0;
            if (enter_ack && cur_region == REG_NONE)
                bus_err_q <= 1'b1;
            if (commit && region_q == REG_LED)
                led_q <= wdata_q[GPIO_W-1:0];
        end
    end

    // Request latch, switch synchronizer and peripheral read capture.
    always_ff @(posedge clk) begin
        sw_q <= sw_in;
        if (state_q == IDLE && CPU_MIO) begin
            addr_q   <= Addr_out;
            wdata_q  <= Data_out;
            mem_w_q  <= mem_w;
            region_q <= cur_region;
        end
        if (enter_ack)
            io_rdata_q <= io_rdata_d;
    end

    // Peripheral read mux; unmapped and RAM regions contribute zero here.
    always_comb begin
        io_rdata_d = '0;
        case (cur_region)
            REG_LED:   io_rdata_d = 32'(led_q);
            REG_SW:    io_rdata_d = 32'(sw_q);
`ifdef MIO_TIMER_EN
            REG_TIMER: io_rdata_d = timer_q;
`endif
            default:   io_rdata_d = '0;
        endcase
    end

    mio_ram #(
        .RAM_WORDS (RAM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (commit && region_q == REG_RAM),
        .re    (enter_ack && cur_region == REG_RAM),
        .addr  (cur_addr[ADDR_W+1:2]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign MIO_ready = (state_q == ACK);
    assign Data_in   = (state_q != ACK) ? 32'd0 :
                       (region_q == REG_RAM) ? ram_rdata : io_rdata_q;
    assign led_out   = led_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb/tb_mio_bus_responder.sv - directed and randomized checks of mio_bus_responder (timer checks follow MIO_TIMER_EN)
module tb_mio_bus_responder;

    localparam int WORDS = 256;
    localparam logic [31:0] LED_A = 32'hF000_0000;
    localparam logic [31:0] SW_A  = 32'hF000_0004;
    localparam logic [31:0] TMR_A = 32'hF000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mio, mem_w;
    logic [31:0] addr, wdata;
    logic        ready;
    logic [31:0] rdata;
    logic [15:0] sw, led;
    logic        err;

    logic        cpu_mio0, mem_w0;
    logic [31:0] addr0, wdata0;
    logic        ready0;
    logic [31:0] rdata0;
    logic [15:0] sw0, led0;
    logic        err0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] ram_m [WORDS];
    bit          known [WORDS];
    logic [15:0] led_m;
    logic        err_m;

    mio_bus_responder #(.RAM_WORDS(WORDS), .WAIT_CYCLES(1), .GPIO_W(16)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(cpu_mio), .mem_w(mem_w), .Addr_out(addr),
        .Data_out(wdata), .MIO_ready(ready), .Data_in(rdata), .sw_in(sw), .led_out(led), .bus_err(err)
    );

    mio_bus_responder #(.RAM_WORDS(WORDS), .WAIT_CYCLES(0), .GPIO_W(16)) dut0 (
        .clk(clk), .reset(reset), .CPU_MIO(cpu_mio0), .mem_w(mem_w0), .Addr_out(addr0),
        .Data_out(wdata0), .MIO_ready(ready0), .Data_in(rdata0), .sw_in(sw0), .led_out(led0), .bus_err(err0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the responder idle; returns #1 after the edge leaving ACK.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err_pulse, output int lat, output int acc);
        cpu_mio = 1'b1; mem_w = w; addr = a; wdata = d;
        @(posedge clk); acc = cyc; #1; lat = 1;
        while (!ready && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        rd = rdata;
        err_pulse = err;
        cpu_mio = 1'b0; mem_w = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        led_m = '0;
        err_m = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, rd1, rd2, prior;
        logic        ep;
        int          lat, acc1, acc2, n, idx, op;
        bit          seen;

        reset = 1'b1; cpu_mio = 0; mem_w = 0; addr = 0; wdata = 0; sw = 16'h0;
        cpu_mio0 = 0; mem_w0 = 0; addr0 = 0; wdata0 = 0; sw0 = 16'h1357;
        for (int i = 0; i < WORDS; i++) known[i] = 0;
        @(posedge clk); #1;
        do_reset();

        check("reset_ready", 32'(ready), 0);
        check("reset_data", rdata, 0);
        check("reset_led", 32'(led), 0);
        check("reset_err", 32'(err), 0);
        check("reset_ready0", 32'(ready0), 0);

        do_req(1, 32'h10, 32'hDEADBEEF, rd, ep, lat, acc1);
        ram_m[4] = 32'hDEADBEEF; known[4] = 1;
        check("wr_latency", 32'(lat), 2);
        check("after_ack_ready", 32'(ready), 0);
        check("after_ack_data", rdata, 0);
        do_req(0, 32'h10, 0, rd, ep, lat, acc1);
        check("rd_latency", 32'(lat), 2);
        check("rd_deadbeef", rd, 32'hDEADBEEF);

        do_req(1, LED_A, 32'h0000_A5A5, rd, ep, lat, acc1);
        led_m = 16'hA5A5;
        check("led_after_ack", 32'(led), 32'hA5A5);
        do_req(0, LED_A, 0, rd, ep, lat, acc1);
        check("led_readback", rd, 32'h0000_A5A5);
        sw = 16'h0F0F;
        do_req(1, SW_A, 32'h1111_2222, rd, ep, lat, acc1);
        do_req(0, SW_A, 0, rd, ep, lat, acc1);
        check("sw_write_ignored_led", 32'(led), 32'hA5A5);
        check("sw_read", rd, 32'h0000_0F0F);
        check("err_clean", 32'(err), 0);

        do_req(1, 32'h3FD, 32'hCAFE_F00D, rd, ep, lat, acc1);
        ram_m[WORDS-1] = 32'hCAFE_F00D; known[WORDS-1] = 1;
        do_req(0, 32'h3FC, 0, rd, ep, lat, acc1);
        check("ram_last_word", rd, 32'hCAFE_F00D);
        check("ram_last_err", 32'(err), 0);

        do_req(0, TMR_A, 0, rd1, ep, lat, acc1);
        n = $urandom_range(3, 20);
        repeat (n) @(posedge clk);
        #1;
        do_req(0, TMR_A, 0, rd2, ep, lat, acc2);
`ifdef MIO_TIMER_EN
        check("timer_diff", rd2 - rd1, 32'(acc2 - acc1));
        check("timer_err", 32'(err), 0);
`else
        check("timer_absent_rd1", rd1, 0);
        check("timer_absent_rd2", rd2, 0);
        check("timer_absent_err", 32'(err), 1);
`endif
        do_reset();

        cpu_mio0 = 1'b1; mem_w0 = 1'b0; addr0 = SW_A;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_ready_%0d", i), 32'(ready0), (i % 2 == 0) ? 1 : 0);
            check($sformatf("hold_data_%0d", i), rdata0, (i % 2 == 0) ? 32'h1357 : 0);
        end
        cpu_mio0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        prior = $urandom;
        do_req(1, 32'h14, prior, rd, ep, lat, acc1);
        ram_m[5] = prior; known[5] = 1;
        cpu_mio = 1; mem_w = 1; addr = 32'h14; wdata = 32'h1234;
        @(posedge clk); #1;
        check("abort_wait_state", 32'(ready), 0);
        reset = 1'b1; cpu_mio = 0; mem_w = 0;
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (ready) seen = 1; end
        reset = 1'b0; led_m = '0; err_m = 0;
        repeat (4) begin @(posedge clk); #1; if (ready) seen = 1; end
        check("abort_no_ready", 32'(seen), 0);
        do_req(0, 32'h14, 0, rd, ep, lat, acc1);
        check("abort_word5", rd, prior);

        prior = $urandom;
        do_req(1, 32'h18, prior, rd, ep, lat, acc1);
        ram_m[6] = prior; known[6] = 1;
        cpu_mio = 1; mem_w = 1; addr = 32'h18; wdata = 32'h5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_ack_pulse", 32'(ready), 1);
        reset = 1'b1; cpu_mio = 0; mem_w = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        do_req(0, 32'h18, 0, rd, ep, lat, acc1);
        check("abort_ack_word6", rd, prior);

        do_req(0, 32'h8000_0000, 0, rd, ep, lat, acc1);
        check("unmapped_data", rd, 0);
        check("unmapped_err_pulse", 32'(ep), 1);
        do_req(0, 32'h10, 0, rd, ep, lat, acc1);
        check("err_sticky_data", rd, 32'hDEADBEEF);
        check("err_sticky", 32'(err), 1);
        do_reset();
        check("err_cleared", 32'(err), 0);
        do_req(0, 32'h400, 0, rd, ep, lat, acc1);
        check("past_ram_unmapped", rd, 0);
        check("past_ram_err", 32'(err), 1);
        do_reset();

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 5);
            idx = $urandom_range(0, WORDS - 1);
            if (op == 1 && !known[idx]) op = 0;
            case (op)
                0: begin
                    rd1 = $urandom;
                    do_req(1, 32'(idx * 4) | $urandom_range(0, 3), rd1, rd, ep, lat, acc1);
                    ram_m[idx] = rd1; known[idx] = 1;
                end
                1: begin
                    do_req(0, 32'(idx * 4) | $urandom_range(0, 3), 0, rd, ep, lat, acc1);
                    check($sformatf("rnd_ram_%0d", i), rd, ram_m[idx]);
                end
                2: begin
                    rd1 = $urandom;
                    do_req(1, LED_A, rd1, rd, ep, lat, acc1);
                    led_m = rd1[15:0];
                    check($sformatf("rnd_led_out_%0d", i), 32'(led), 32'(led_m));
                end
                3: begin
                    do_req(0, LED_A | $urandom_range(0, 3), 0, rd, ep, lat, acc1);
                    check($sformatf("rnd_led_rd_%0d", i), rd, 32'(led_m));
                end
                4: begin
                    sw = 16'($urandom);
                    do_req(0, SW_A, 0, rd, ep, lat, acc1);
                    check($sformatf("rnd_sw_%0d", i), rd, 32'(sw));
                end
                default: begin
                    rd1 = {4'($urandom_range(1, 7)), 28'($urandom)};
                    do_req(1'($urandom), rd1, $urandom, rd, ep, lat, acc1);
                    err_m = 1'b1;
                    check($sformatf("rnd_unmapped_%0d", i), rd, 0);
                end
            endcase
            check($sformatf("rnd_lat_%0d", i), 32'(lat), 2);
            check($sformatf("rnd_err_%0d", i), 32'(err), 32'(err_m));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
